// File: rtl/clock_mode_ctrl_pkg.sv
// Shared definitions for the MM:SS clock controller: state encodings,
// BCD limits and digit_blank bit positions.
package clock_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PAUSE   = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX = 4'd5;

    localparam int DIGIT_SEC_ONES = 0;
    localparam int DIGIT_SEC_TENS = 1;
    localparam int DIGIT_MIN_ONES = 2;
    localparam int DIGIT_MIN_TENS = 3;

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter modulo 60 with clear priority over increment.
// carry flags the increment that rolls 59 back to 00.
module bcd_mod60
    import clock_mode_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       carry
);

    logic [3:0] ones_reg, ones_next;
    logic [3:0] tens_reg, tens_next;
    logic       at_max;

    assign at_max = (ones_reg == ONES_MAX) && (tens_reg == TENS_MAX);
    assign carry  = inc && at_max;

    always_comb begin
        ones_next = ones_reg;
        tens_next = tens_reg;
        if (clr) begin
            ones_next = 4'd0;
            tens_next = 4'd0;
        end else if (inc) begin
            if (ones_reg == ONES_MAX) begin
                ones_next = 4'd0;
                tens_next = (tens_reg == TENS_MAX) ? 4'd0 : tens_reg + 4'd1;
            end else begin
                ones_next = ones_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_reg <= 4'd0;
            tens_reg <= 4'd0;
        end else begin
            ones_reg <= ones_next;
            tens_reg <= tens_next;
        end
    end

    assign ones = ones_reg;
    assign tens = tens_reg;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode FSM for the MM:SS wall clock: run/pause/set control, minute carry,
// rollover pulse and the blink timer that flashes the field being edited.
module clock_mode_ctrl
    import clock_mode_ctrl_pkg::*;
#(
    parameter int BLINK_CYCLES = 50_000_000
) (
    input  logic       sysCLK,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_run,
    input  logic       btn_inc,
    input  logic       btn_clr,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] digit_blank,
    output logic [1:0] mode,
    output logic       wrap
);

    localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] BLINK_TERM = CW'(BLINK_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          blink_phase_reg, blink_phase_next;
    logic [3:0]    blank_reg, blank_next;
    logic          wrap_reg, wrap_next;

    logic in_run, in_set, entering_set;
    logic sec_inc, min_inc, sec_carry, min_carry;

    assign in_run = (state_reg == ST_RUN);
    assign in_set = (state_reg == ST_SET_MIN) || (state_reg == ST_SET_SEC);

    // Increments follow the current state; the transition lands on the same edge.
    assign sec_inc = (in_run && tick_1hz) || ((state_reg == ST_SET_SEC) && btn_inc);
    assign min_inc = (in_run && sec_carry) || ((state_reg == ST_SET_MIN) && btn_inc);

    bcd_mod60 u_sec (
        .clk   (sysCLK),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (btn_clr),
        .ones  (sec_ones),
        .tens  (sec_tens),
        .carry (sec_carry)
    );

    bcd_mod60 u_min (
        .clk   (sysCLK),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (btn_clr),
        .ones  (min_ones),
        .tens  (min_tens),
        .carry (min_carry)
    );

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_RUN:     if (btn_mode) state_next = ST_SET_MIN;
                        else if (btn_run) state_next = ST_PAUSE;
            ST_PAUSE:   if (btn_mode) state_next = ST_SET_MIN;
                        else if (btn_run) state_next = ST_RUN;
            ST_SET_MIN: if (btn_mode) state_next = ST_SET_SEC;
            ST_SET_SEC: if (btn_mode) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    assign wrap_next = in_run && min_carry && !btn_clr;

    // Entering a SET state restarts the blink so the field starts visible.
    assign entering_set = (state_next != state_reg) &&
                          ((state_next == ST_SET_MIN) || (state_next == ST_SET_SEC));

    always_comb begin
        blink_cnt_next   = '0;
        blink_phase_next = 1'b0;
        blank_next       = 4'b0000;
        if (!entering_set && in_set) begin
            if (blink_cnt_reg == BLINK_TERM) begin
                blink_phase_next = !blink_phase_reg;
            end else begin
                blink_cnt_next   = blink_cnt_reg + 1'b1;
                blink_phase_next = blink_phase_reg;
            end
        end
        if (blink_phase_next) begin
            if (state_next == ST_SET_MIN) begin
                blank_next[DIGIT_MIN_TENS] = 1'b1;
                blank_next[DIGIT_MIN_ONES] = 1'b1;
            end else if (state_next == ST_SET_SEC) begin
                blank_next[DIGIT_SEC_TENS] = 1'b1;
                blank_next[DIGIT_SEC_ONES] = 1'b1;
            end
        end
    end

    always_ff @(posedge sysCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RUN;
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            blank_reg       <= 4'b0000;
            wrap_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            blink_cnt_reg   <= blink_cnt_next;
            blink_phase_reg <= blink_phase_next;
            blank_reg       <= blank_next;
            wrap_reg        <= wrap_next;
        end
    end

    assign mode        = state_reg;
    assign digit_blank = blank_reg;
    assign wrap        = wrap_reg;

endmodule
